// File: rtl/uart_hex_byte_receiver.sv
// UART 8N1 ASCII-hex receiver feeding a FWFT byte FIFO; define UART_HEX_LOWERCASE_EN to also accept 'a'-'f'.
// Latency: FIFO write one cycle after the low char's stop sample, rx_valid the cycle after that.
// Backpressure: RTS high at occupancy >= depth-1; a push into a full FIFO is dropped with overrun_err.
module uart_hex_byte_receiver #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RXD,
    output logic       RTS,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       char_err,
    output logic       overrun_err
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int NW    = FIFO_ADDR_WIDTH + 1;
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);
    localparam logic [NW-1:0] RTS_CNT  = NW'(DEPTH - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rxd_meta, rxd_sync;
    state_t        state, state_nxt;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          char_done;

    logic          is_hex, is_eol;
    logic [3:0]    nib, hi_reg;
    logic          phase_lo;
    logic          push_vld;
    logic [7:0]    push_dat;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0]              count, count_nxt;
    logic                       pop, push_ok, full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        char_done   = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (!rxd_sync) begin
                    state_nxt   = START;
                    bit_cnt_nxt = '0;
                end
            end
            START: begin
                // A start edge that is high again at mid-bit was noise.
                if (clk_cnt == HALF_END) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = rxd_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rxd_sync, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_nxt = '0;
                    char_done   = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        is_hex = 1'b0;
        nib    = shift[3:0];
        if (shift >= 8'h30 && shift <= 8'h39) begin
            is_hex = 1'b1;
        end else if (shift >= 8'h41 && shift <= 8'h46) begin
            is_hex = 1'b1;
            nib    = shift[3:0] + 4'd9;
        end
`ifdef UART_HEX_LOWERCASE_EN
        else if (shift >= 8'h61 && shift <= 8'h66) begin
            is_hex = 1'b1;
            nib    = shift[3:0] + 4'd9;
        end
`endif
    end

    assign is_eol = (shift == 8'h0D) || (shift == 8'h0A);

    // Any bad frame or non-hex char realigns the pair boundary to the high nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            char_err  <= 1'b0;
            push_vld  <= 1'b0;
            push_dat  <= '0;
            hi_reg    <= '0;
            phase_lo  <= 1'b0;
        end else begin
            frame_err <= char_done && !rxd_sync;
            char_err  <= char_done && rxd_sync && !is_hex && !is_eol;
            push_vld  <= char_done && rxd_sync && is_hex && phase_lo;
            push_dat  <= {hi_reg, nib};
            if (char_done) begin
                if (rxd_sync && is_hex) begin
                    phase_lo <= !phase_lo;
                    if (!phase_lo) hi_reg <= nib;
                end else begin
                    phase_lo <= 1'b0;
                end
            end
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign pop      = rx_valid && rx_ready;
    assign push_ok  = push_vld && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)      count_nxt = count + 1'b1;
        else if (!push_ok && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            RTS         <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            // One slot of headroom covers the byte already on the wire when RTS rises.
            RTS         <= (count_nxt >= RTS_CNT);
            overrun_err <= push_vld && full && !pop;
        end
    end

endmodule
